bn_param_ctrl: RTL and testbench

BN_PARAM_CTRL -- requirements
Module: bn_param_ctrl

---
 rtl/bn_param_ctrl.sv | 144 ++++++++++++++
 tb/tb_bn_param_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_param_ctrl.sv
// rtl/bn_param_ctrl.sv - double-buffered BN/ReLU/quantize parameter banks with frame-aligned swap
// Shadow bank loads from the cfg stream while the active bank drives the datapath.
module bn_param_ctrl #(
  parameter int NO_CH     = 10,
  parameter int BW_IN     = 12,
  parameter int AB_BW     = 12,
  parameter int FRAME_LEN = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_vld,
  output logic                     cfg_rdy,
  input  logic [AB_BW-1:0]         cfg_data,
  input  logic                     s_vld,
  output logic                     s_rdy,
  input  logic [NO_CH*BW_IN-1:0]   s_data,
  output logic                     vld_in,
  output logic [NO_CH*BW_IN-1:0]   data_in,
  output logic [NO_CH*AB_BW-1:0]   a,
  output logic [NO_CH*AB_BW-1:0]   b,
  output logic [NO_CH*BW_IN-1:0]   x_min,
  output logic [NO_CH*BW_IN-1:0]   x_max,
  output logic                     bank_sel,
  output logic                     swap
);

  localparam int CH_W = (NO_CH > 1) ? $clog2(NO_CH) : 1;
  localparam int FC_W = $clog2(FRAME_LEN);

  typedef enum logic {LOAD, PENDING} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             grp_q, grp_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [FC_W-1:0]        frame_q, frame_d;
  logic                   bank_sel_q;
  logic                   act_valid_q;
  logic                   vld_in_q;
  logic [NO_CH*BW_IN-1:0] data_in_q;

  logic [AB_BW-1:0]       a_q    [2][NO_CH];
  logic [AB_BW-1:0]       b_q    [2][NO_CH];
  logic [BW_IN-1:0]       xmin_q [2][NO_CH];
  logic [BW_IN-1:0]       xmax_q [2][NO_CH];

  logic cfg_fire;
  logic s_fire;
  logic swap_cond;
  logic last_ch;
  logic shadow;

  // Swap only when the frame boundary is reached and the output register is empty.
  assign swap_cond = (state_q == PENDING) && (frame_q == '0) && !vld_in_q;
  assign cfg_rdy   = !rst && (state_q == LOAD);
  assign s_rdy     = !rst && act_valid_q && !swap_cond;
  assign swap      = !rst && swap_cond;
  assign cfg_fire  = cfg_vld && cfg_rdy;
  assign s_fire    = s_vld && s_rdy;
  assign last_ch   = (ch_q == CH_W'(NO_CH - 1));
  assign shadow    = ~bank_sel_q;

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    case (state_q)
      LOAD: begin
        if (cfg_fire) begin
          if (last_ch) begin
            ch_d  = '0;
            grp_d = grp_q + 2'd1;
            if (grp_q == 2'd3) state_d = PENDING;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      PENDING: begin
        if (swap_cond) begin
          state_d = LOAD;
          grp_d   = '0;
          ch_d    = '0;
        end
      end
      default: state_d = LOAD;
    endcase
    if (s_fire) begin
      frame_d = (frame_q == FC_W'(FRAME_LEN - 1)) ? '0 : frame_q + FC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      grp_q       <= '0;
      ch_q        <= '0;
      frame_q     <= '0;
      bank_sel_q  <= 1'b0;
      act_valid_q <= 1'b0;
      vld_in_q    <= 1'b0;
      data_in_q   <= '0;
      for (int bk = 0; bk < 2; bk++) begin
        for (int i = 0; i < NO_CH; i++) begin
          a_q[bk][i]    <= '0;
          b_q[bk][i]    <= '0;
          xmin_q[bk][i] <= '0;
          xmax_q[bk][i] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      ch_q     <= ch_d;
      frame_q  <= frame_d;
      vld_in_q <= s_fire;
      if (s_fire) data_in_q <= s_data;
      if (swap_cond) begin
        bank_sel_q  <= ~bank_sel_q;
        act_valid_q <= 1'b1;
      end
      if (cfg_fire) begin
        case (grp_q)
          2'd0:    a_q[shadow][ch_q]    <= cfg_data;
          2'd1:    b_q[shadow][ch_q]    <= cfg_data;
          2'd2:    xmin_q[shadow][ch_q] <= cfg_data[BW_IN-1:0];
          default: xmax_q[shadow][ch_q] <= cfg_data[BW_IN-1:0];
        endcase
      end
    end
  end

  for (genvar i = 0; i < NO_CH; i++) begin : g_lane
    assign a[i*AB_BW +: AB_BW]     = a_q[bank_sel_q][i];
    assign b[i*AB_BW +: AB_BW]     = b_q[bank_sel_q][i];
    assign x_min[i*BW_IN +: BW_IN] = xmin_q[bank_sel_q][i];
    assign x_max[i*BW_IN +: BW_IN] = xmax_q[bank_sel_q][i];
  end

  assign vld_in   = vld_in_q;
  assign data_in  = data_in_q;
  assign bank_sel = bank_sel_q;

endmodule

// File: tb/tb_bn_param_ctrl.sv
// tb/tb_bn_param_ctrl.sv - directed bench for bn_param_ctrl
module tb_bn_param_ctrl;
  localparam int NCH = 10;
  localparam int W   = NCH * 12;

  logic         clk;
  logic         rst;
  logic         cfg_vld;
  logic         cfg_rdy;
  logic [11:0]  cfg_data;
  logic         s_vld;
  logic         s_rdy;
  logic [W-1:0] s_data;
  logic         vld_in;
  logic [W-1:0] data_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] x_min;
  logic [W-1:0] x_max;
  logic         bank_sel;
  logic         swap;

  int n_vec;
  int n_err;
  int swap_cnt;
  int w;
  logic bad_a, bad_sel, bad_swap, bad_rdy;

  bn_param_ctrl #(.NO_CH(10), .BW_IN(12), .AB_BW(12), .FRAME_LEN(128)) dut (
    .clk(clk), .rst(rst),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_data(cfg_data),
    .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
    .vld_in(vld_in), .data_in(data_in),
    .a(a), .b(b), .x_min(x_min), .x_max(x_max),
    .bank_sel(bank_sel), .swap(swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (swap === 1'b1) swap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [11:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*12 +: 12] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] pat(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*12 +: 12] = 12'(k + i * 256);
    return r;
  endfunction

  function automatic logic [11:0] wval(input int idx, input logic [11:0] av, input logic [11:0] bv,
                                       input logic [11:0] mv, input logic [11:0] xv);
    case (idx / NCH)
      0:       return av;
      1:       return bv;
      2:       return mv;
      default: return xv;
    endcase
  endfunction

  task automatic cfg_word(input logic [11:0] d);
    cfg_vld  = 1'b1;
    cfg_data = d;
    tick();
    cfg_vld  = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; swap_cnt = 0;
    rst = 1'b1; cfg_vld = 1'b0; cfg_data = '0; s_vld = 1'b0; s_data = '0;
    tick();
    tick();
    chk("rst_cfg_rdy", W'(cfg_rdy), W'(0));
    chk("rst_s_rdy", W'(s_rdy), W'(0));
    rst = 1'b0;
    #1;
    chk("init_bank_sel", W'(bank_sel), W'(0));
    chk("init_swap", W'(swap), W'(0));
    chk("init_vld_in", W'(vld_in), W'(0));
    chk("init_data_in", data_in, '0);
    chk("init_a", a, '0);
    chk("init_x_max", x_max, '0);
    chk("init_cfg_rdy", W'(cfg_rdy), W'(1));
    chk("init_s_rdy", W'(s_rdy), W'(0));

    // No bank loaded: upstream must be stalled indefinitely.
    s_vld = 1'b1; s_data = pat(9);
    bad_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_rdy !== 1'b0 || vld_in !== 1'b0) bad_rdy = 1'b1;
    end
    chk("idle_stall", W'(bad_rdy), W'(0));
    s_vld = 1'b0;

    for (int i = 0; i < 40; i++) cfg_word(wval(i, 12'd7, 12'd17, 12'd4095, 12'd41));
    chk("b1_swap_pulse", W'(swap), W'(1));
    chk("b1_sel_before", W'(bank_sel), W'(0));
    chk("b1_cfg_rdy_pend", W'(cfg_rdy), W'(0));
    chk("b1_s_rdy_swap", W'(s_rdy), W'(0));
    tick();
    chk("b1_bank_sel", W'(bank_sel), W'(1));
    chk("b1_swap_low", W'(swap), W'(0));
    chk("b1_a", a, rep(12'd7));
    chk("b1_b", b, rep(12'd17));
    chk("b1_x_min", x_min, rep(12'd4095));
    chk("b1_x_max", x_max, rep(12'd41));
    chk("b1_s_rdy", W'(s_rdy), W'(1));
    chk("b1_cfg_rdy", W'(cfg_rdy), W'(1));
    chk("b1_swap_cnt", W'(swap_cnt), W'(1));

    for (int k = 0; k < 4; k++) begin
      s_vld = 1'b1; s_data = pat(k);
      tick();
      chk($sformatf("beat%0d_vld", k), W'(vld_in), W'(1));
      chk($sformatf("beat%0d_data", k), data_in, pat(k));
    end
    s_vld = 1'b0; s_data = pat(77);
    tick();
    chk("gap_vld", W'(vld_in), W'(0));
    chk("gap_hold", data_in, pat(3));

    // Beats 4..127; second bank streams in from beat 5, then cfg_vld stays high while pending.
    w = 0;
    bad_a = 1'b0; bad_sel = 1'b0; bad_swap = 1'b0; bad_rdy = 1'b0;
    for (int beat = 4; beat < 128; beat++) begin
      s_vld = 1'b1; s_data = pat(beat);
      if (beat >= 5 && w < 40) begin
        cfg_vld = 1'b1; cfg_data = wval(w, 12'd3, 12'd5, 12'd1, 12'd100);
      end else if (w >= 40) begin
        cfg_vld = 1'b1; cfg_data = 12'hABC;
      end else begin
        cfg_vld = 1'b0;
      end
      tick();
      if (beat >= 5 && w < 40) w++;
      if (a !== rep(12'd7)) bad_a = 1'b1;
      if (bank_sel !== 1'b1) bad_sel = 1'b1;
      if (swap !== 1'b0) bad_swap = 1'b1;
      if (s_rdy !== 1'b1) bad_rdy = 1'b1;
    end
    chk("frame_a_const", W'(bad_a), W'(0));
    chk("frame_sel_const", W'(bad_sel), W'(0));
    chk("frame_no_swap", W'(bad_swap), W'(0));
    chk("frame_s_rdy", W'(bad_rdy), W'(0));
    chk("beat127_vld", W'(vld_in), W'(1));
    chk("beat127_data", data_in, pat(127));
    chk("pend_cfg_rdy", W'(cfg_rdy), W'(0));

    s_vld = 1'b0;
    tick();
    chk("b2_swap_pulse", W'(swap), W'(1));
    chk("b2_s_rdy_drop", W'(s_rdy), W'(0));
    chk("b2_cfg_rdy", W'(cfg_rdy), W'(0));
    chk("b2_a_old", a, rep(12'd7));
    s_vld = 1'b1; s_data = pat(200); cfg_vld = 1'b0;
    tick();
    chk("b2_bank_sel", W'(bank_sel), W'(0));
    chk("b2_a", a, rep(12'd3));
    chk("b2_b", b, rep(12'd5));
    chk("b2_x_min", x_min, rep(12'd1));
    chk("b2_x_max", x_max, rep(12'd100));
    chk("b2_swap_low", W'(swap), W'(0));
    chk("b2_s_rdy_back", W'(s_rdy), W'(1));
    chk("b2_vld_in", W'(vld_in), W'(0));
    chk("b2_cfg_rdy", W'(cfg_rdy), W'(1));
    chk("b2_swap_cnt", W'(swap_cnt), W'(2));
    tick();
    chk("post_vld", W'(vld_in), W'(1));
    chk("post_data", data_in, pat(200));
    s_vld = 1'b0;

    // Word counter must restart at 0 after the swap: pending only after 40 more words.
    for (int i = 0; i < 39; i++) cfg_word(wval(i, 12'd9, 12'd9, 12'd9, 12'd9));
    chk("b3_39_cfg_rdy", W'(cfg_rdy), W'(1));
    cfg_word(12'd9);
    chk("b3_40_cfg_rdy", W'(cfg_rdy), W'(0));
    chk("b3_a_const", a, rep(12'd3));
    chk("b3_no_swap", W'(swap), W'(0));

    rst = 1'b1;
    #1;
    chk("rst2_cfg_rdy", W'(cfg_rdy), W'(0));
    chk("rst2_s_rdy", W'(s_rdy), W'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cfg_word(wval(i, 12'd5, 12'd5, 12'd5, 12'd5));
    chk("mid_cfg_rdy", W'(cfg_rdy), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst3_a", a, '0);
    chk("rst3_x_max", x_max, '0);
    chk("rst3_bank_sel", W'(bank_sel), W'(0));
    chk("rst3_swap", W'(swap), W'(0));
    chk("rst3_vld_in", W'(vld_in), W'(0));
    chk("rst3_data_in", data_in, '0);
    chk("rst3_cfg_rdy", W'(cfg_rdy), W'(1));
    chk("rst3_s_rdy", W'(s_rdy), W'(0));

    s_vld = 1'b1; s_data = pat(50);
    bad_rdy = 1'b0;
    for (int i = 0; i < 39; i++) begin
      cfg_word(wval(i, 12'd11, 12'd12, 12'd13, 12'd14));
      if (s_rdy !== 1'b0) bad_rdy = 1'b1;
    end
    chk("fresh_s_rdy_low", W'(bad_rdy), W'(0));
    chk("fresh_no_swap", W'(swap), W'(0));
    cfg_word(12'd14);
    chk("fresh_swap", W'(swap), W'(1));
    tick();
    chk("fresh_bank_sel", W'(bank_sel), W'(1));
    chk("fresh_a", a, rep(12'd11));
    chk("fresh_x_min", x_min, rep(12'd13));
    chk("fresh_s_rdy", W'(s_rdy), W'(1));
    chk("fresh_swap_cnt", W'(swap_cnt), W'(3));
    tick();
    chk("fresh_vld", W'(vld_in), W'(1));
    chk("fresh_data", data_in, pat(50));
    s_vld = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
